uart_rx_deframer: RTL and testbench

- UART receive front end that feeds the receive-side uart_fifo.
- Synchronises the asynchronous rx line and detects start bits.
- Samples each bit at its centre, checks the optional parity bit and the stop bit.
- Issues a one-cycle write strobe with the assembled word, which connects directly to the FIFO `wr`/`din` inputs.

---
 rtl/uart_rx_deframer_if.sv | 27 ++
 rtl/uart_rx_deframer.sv | 154 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframer_if.sv
// Receive-side word strobe bus between the UART deframer and the receive FIFO.
// The deframer drives it as master; the FIFO write port consumes it as slave.
interface uart_rx_deframer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  frame_err;
  logic                  parity_err;
  logic                  busy;

  modport master (
    output wr,
    output dout,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input wr,
    input dout,
    input frame_err,
    input parity_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx, centre-samples start/data/parity/stop
// bits, and emits a one-cycle write strobe or error pulse per received frame.
module uart_rx_deframer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter string       PARITY       = "NONE",
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  uart_rx_deframer_if.master rxo
);

  localparam bit          PAR_EN  = (PARITY != "NONE");
  localparam bit          PAR_ODD = (PARITY == "ODD");
  localparam int unsigned CW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW      = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  if (!(PARITY == "NONE" || PARITY == "EVEN" || PARITY == "ODD")) begin : g_bad_parity
    $error("uart_rx_deframer: PARITY must be NONE, EVEN or ODD");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_rx_deframer: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx_deframer: CLKS_PER_BIT must be at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_deframer: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    rx_s;
  logic [CW-1:0]           cnt;
  logic                    tick;
  logic [BW-1:0]           bit_idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    perr;
  logic                    par_mismatch;
  logic                    wr_nxt;
  logic                    fe_nxt;
  logic                    pe_nxt;
  logic                    busy_c;
  logic                    wr_q;
  logic                    fe_q;
  logic                    pe_q;
  logic [DATA_WIDTH-1:0]   dout_q;

  assign rx_s         = sync[SYNC_STAGES-1];
  assign tick         = (cnt == '0);
  assign par_mismatch = rx_s ^ (^shreg) ^ PAR_ODD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (!rx_s) state_nxt = ST_START;
      ST_START:  if (tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && bit_idx == LAST_BIT) state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP:   if (tick) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outcome of the stop-bit mid-sample; registered below so the strobe lands
  // one cycle later together with the dout update.
  always_comb begin
    wr_nxt = 1'b0;
    fe_nxt = 1'b0;
    pe_nxt = 1'b0;
    busy_c = (state != ST_IDLE);
    if (state == ST_STOP && tick) begin
      wr_nxt = rx_s && !perr;
      pe_nxt = rx_s && perr && PAR_EN;
      fe_nxt = !rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};

      // Preloading the half-bit count while idle puts the first tick mid start bit.
      if (state == ST_IDLE) begin
        cnt <= HALF_LOAD;
      end else if (tick) begin
        cnt <= FULL_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end

      if (state == ST_START) begin
        bit_idx <= '0;
        perr    <= 1'b0;
      end else if (state == ST_DATA && tick) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
      end

      if (state == ST_PARITY && tick) begin
        perr <= par_mismatch;
      end

      wr_q <= wr_nxt;
      fe_q <= fe_nxt;
      pe_q <= pe_nxt;
      if (wr_nxt) begin
        dout_q <= shreg;
      end
    end
  end

  assign rxo.wr         = wr_q;
  assign rxo.dout       = dout_q;
  assign rxo.frame_err  = fe_q;
  assign rxo.parity_err = pe_q;
  assign rxo.busy       = busy_c;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: one PARITY="NONE" and one PARITY="EVEN" instance,
// frame-level expected outcomes queued at send time and popped by a monitor.
module tb_uart_rx_deframer;

  localparam int unsigned CPB  = 16;
  localparam int unsigned SYNC = 2;
  localparam int K_WR = 0;
  localparam int K_FE = 1;
  localparam int K_PE = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_n  = 1'b1;
  logic rx_e  = 1'b1;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  ev_t  exp0[$];
  ev_t  exp1[$];
  logic [7:0] last_good [2];
  bit   gap_check = 1'b0;
  int   gap_cnt   = 0;
  int   prev_wr   = 0;
  bit   busy_chk  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_deframer_if #(.DATA_WIDTH(8)) if_n ();
  uart_rx_deframer_if #(.DATA_WIDTH(8)) if_e ();

  uart_rx_deframer #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY("NONE"), .SYNC_STAGES(SYNC)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .rx(rx_n), .rxo(if_n)
  );

  uart_rx_deframer #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY("EVEN"), .SYNC_STAGES(SYNC)
  ) dut_e (
    .clk(clk), .rst_n(rst_n), .rx(rx_e), .rxo(if_e)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon(input int who, input logic wr, input logic fe, input logic pe,
                     input logic [7:0] d);
    ev_t e;
    int  n;
    int  kind;
    if (wr || fe || pe) begin
      n = int'(wr) + int'(fe) + int'(pe);
      check($sformatf("strobe_exclusive_dut%0d", who), n, 1);
      if ((who == 0 && exp0.size() == 0) || (who == 1 && exp1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event_dut%0d: actual wr=%0b fe=%0b pe=%0b required no event (t=%0t)",
                 who, wr, fe, pe, $time);
      end else begin
        if (who == 0) e = exp0.pop_front();
        else          e = exp1.pop_front();
        kind = wr ? K_WR : (fe ? K_FE : K_PE);
        check($sformatf("event_kind_dut%0d", who), kind, e.kind);
        if (e.kind == K_WR) begin
          check($sformatf("dout_on_wr_dut%0d", who), d, e.data);
          last_good[who] = e.data;
        end else begin
          check($sformatf("dout_held_dut%0d", who), d, last_good[who]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_good[0] = 8'h00;
      last_good[1] = 8'h00;
      busy_chk     = 1'b0;
      gap_cnt      = 0;
    end else begin
      if (busy_chk) begin
        check("busy_after_wr", if_n.busy, 1'b0);
        busy_chk = 1'b0;
      end
      mon(0, if_n.wr, if_n.frame_err, if_n.parity_err, if_n.dout);
      mon(1, if_e.wr, if_e.frame_err, if_e.parity_err, if_e.dout);
      if (if_n.wr) begin
        busy_chk = 1'b1;
        if (gap_check) begin
          if (gap_cnt > 0) begin
            checks++;
            if (cyc - prev_wr < 10 * CPB - 1 || cyc - prev_wr > 10 * CPB + 1) begin
              failures++;
              $display("FAIL wr_spacing: actual=%0d required=%0d+-1", cyc - prev_wr, 10 * CPB);
            end
          end
          gap_cnt++;
          prev_wr = cyc;
        end
      end
      if (!gap_check) gap_cnt = 0;
    end
  end

  task automatic drive(input int who, input logic v, input int cycles);
    if (who == 0) rx_n = v;
    else          rx_e = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Expected outcome from frame content alone: bad stop wins, then parity, else a word.
  task automatic send_frame(input int who, input logic [7:0] d, input logic pbit, input logic stop);
    ev_t e;
    e.data = d;
    if (!stop)                          e.kind = K_FE;
    else if (who == 1 && pbit != (^d))  e.kind = K_PE;
    else                                e.kind = K_WR;
    if (who == 0) exp0.push_back(e);
    else          exp1.push_back(e);
    drive(who, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(who, d[i], CPB);
    if (who == 1) drive(who, pbit, CPB);
    drive(who, stop, CPB);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       pbit;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr", if_n.wr, 1'b0);
    check("reset_dout", if_n.dout, 8'h00);
    check("reset_frame_err", if_n.frame_err, 1'b0);
    check("reset_parity_err", if_n.parity_err, 1'b0);
    check("reset_busy", if_n.busy, 1'b0);
    check("reset_busy_even", if_e.busy, 1'b0);
    rst_n = 1'b1;
    drive(0, 1'b1, 2 * CPB);

    send_frame(0, 8'hA5, 1'b0, 1'b1);
    drive(0, 1'b1, 2 * CPB);

    gap_check = 1'b1;
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    gap_check = 1'b0;
    drive(0, 1'b1, 2 * CPB);

    drive(0, 1'b0, 4);
    drive(0, 1'b1, 8 + SYNC + 2 - 4);
    check("glitch_busy", if_n.busy, 1'b0);
    drive(0, 1'b1, 2 * CPB);

    send_frame(0, 8'h55, 1'b0, 1'b0);
    drive(0, 1'b0, 40 * CPB);
    check("break_busy_held", if_n.busy, 1'b1);
    drive(0, 1'b1, SYNC + 2);
    check("break_released", if_n.busy, 1'b0);
    drive(0, 1'b1, CPB);
    send_frame(0, 8'h12, 1'b0, 1'b1);
    drive(0, 1'b1, 2 * CPB);

    send_frame(1, 8'h03, 1'b0, 1'b1);
    drive(1, 1'b1, 2 * CPB);
    send_frame(1, 8'h03, 1'b1, 1'b1);
    drive(1, 1'b1, 2 * CPB);

    d = 8'hC3;
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(0, d[i], CPB);
    drive(0, d[4], CPB / 2);
    rst_n = 1'b0;
    #2;
    check("midreset_wr", if_n.wr, 1'b0);
    check("midreset_frame_err", if_n.frame_err, 1'b0);
    check("midreset_busy", if_n.busy, 1'b0);
    check("midreset_dout", if_n.dout, 8'h00);
    rx_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    drive(0, 1'b1, 2 * CPB);

    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(0, d, 1'b0, stop);
      if (!stop) begin
        drive(0, 1'b0, $urandom_range(0, 3) * CPB);
        drive(0, 1'b1, CPB);
      end else begin
        drive(0, 1'b1, $urandom_range(0, 2) * CPB);
      end
    end

    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom);
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(1, d, pbit, 1'b1);
      drive(1, 1'b1, $urandom_range(0, 2) * CPB);
    end

    drive(0, 1'b1, 4 * CPB);
    check("pending_events_dut0", exp0.size(), 0);
    check("pending_events_dut1", exp1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
